alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit registered adder datapath. Accepts one operation at a time (opcode, A, B) on a valid/ready input port, computes one of 16 arithmetic/logic/shift/compare functions, and presents a registered WIDTH+1-bit result on a valid/ready output port. Single-cycle ops finish in one cycle; MUL and DIV run iteratively over WIDTH cycles. Sits between the operand sequencer and the result writeback stage.

## Interface
- WIDTH, 8, operand width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  4  opcode (encoding below)
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  WIDTH+1  result; z[WIDTH] is carry/borrow/overflow/error flag

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR, 14 EQ, 15 GT.
- ADD: z = a + b (full WIDTH+1 sum).
- SUB: z[W-1:0] = (a − b) mod 2^W; z[W] = 1 iff a < b.
- MUL: z[W-1:0] = low half of a×b; z[W] = OR of high half.
- DIV: z[W-1:0] = floor(a/b), z[W] = 0. b = 0: z[W-1:0] = all ones, z[W] = 1.
- SHL: z = {a, 1'b0}. SHR: z[W-1:0] = a >> 1, z[W] = a[0].
- ROL/ROR: rotate a by one; z[W] = 0.
- Bitwise ops: z[W-1:0] = result, z[W] = 0.
- EQ/GT: z = 1 if a == b / a > b, else 0.
- FSM: IDLE → (accept, single-cycle op) → DONE; IDLE → (accept, MUL/DIV) → BUSY; BUSY → DONE when iteration counter reaches WIDTH−1; DONE → IDLE on out_valid && out_ready.
- in_ready = 1 only in IDLE and rst low. out_valid = 1 only in DONE.
- Operands and opcode latched at accept; input changes afterwards ignored.
- z and out_valid are registers; z held stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE, out_valid 0, z 0, iteration counter 0; in_ready 0 during rst, 1 the cycle after.
- Accept on rising edge with in_valid && in_ready.
- Single-cycle ops: out_valid high 1 cycle after accept.
- MUL/DIV: BUSY exactly WIDTH cycles; out_valid high WIDTH+1 cycles after accept.
- Result transfer on edge with out_valid && out_ready; in_ready high the next cycle (no accept in DONE; peak throughput one op per 2 cycles).
- rst asserted mid-BUSY or in DONE: operation discarded, no out_valid, IDLE next cycle.
- out_ready ignored outside DONE; in_valid ignored outside IDLE.

## Structure
- Shared package alu_pkg: opcode enum (4-bit, values above), ALU_OP_W = 4, FSM state enum (IDLE/BUSY/DONE).
- One sub-module alu_iter_muldiv: shift-add multiplier and restoring divider sharing one accumulator and a $clog2(WIDTH)-bit counter; start/done handshake to the top FSM.
- Top: FSM, operand/result registers, combinational single-cycle function unit.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 → z=0x100 one cycle after accept; SUB a=0x03 b=0x05 → z=0x1FE.
- MUL a=0x10 b=0x10 → z=0x100 (low 0x00, flag 1) exactly 9 cycles after accept; MUL 0x0F×0x0F → z=0x0E1.
- DIV a=0xC8 b=0x07 → z=0x01C after 9 cycles; DIV b=0 → z=0x1FF.
- SHR a=0x81 → z=0x140; ROR a=0x01 → z=0x080; EQ 0x5A,0x5A → z=1; GT 0x10,0x20 → z=0.
- Backpressure: out_ready low 5 cycles after ADD result → z and out_valid stable, in_ready 0 throughout; releases, IDLE next cycle.
- rst pulsed 3 cycles into a DIV → no out_valid, in_ready 1 cycle after rst drops; following ADD correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
// Also provides the helper that tells the top which opcodes run iteratively.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_EQ   = 4'd14,
        OP_GT   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iter_op(alu_op_e op_v);
        return (op_v == OP_MUL) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Both share the {hi_q, lo_q} accumulator and the iteration counter.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    // MUL: opnd_q is the multiplicand, lo_q shifts the multiplier out as the
    // product shifts in. DIV: opnd_q is the divisor, hi_q the partial remainder
    // and lo_q shifts the dividend out as quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        hi_d      = mul_sum[WIDTH:1];
        lo_d      = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                hi_d = div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= '0;
            opnd_q <= is_div ? b : a;
            hi_q   <= '0;
            lo_q   <= is_div ? a : b;
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // The final step's result is handed over combinationally so the top can
    // register it on the same edge the last iteration completes.
    assign done   = busy_q && (cnt_q == LAST);
    assign res_hi = hi_d;
    assign res_lo = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle function unit plus iterative MUL/DIV,
// with a registered WIDTH+1-bit result on a valid/ready output port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH:0]      z
);

    alu_state_e       state_q;
    alu_op_e          op_q;
    logic             b_zero_q;
    logic [WIDTH:0]   z_q;
    logic             out_valid_q;

    alu_op_e          op_e;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH:0]   md_z;
    logic [WIDTH:0]   sc_z;

    assign op_e     = alu_op_e'(op);
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_iter_op(op_e);

    always_comb begin
        sc_z = '0;
        case (op_e)
            OP_ADD:  sc_z = {1'b0, a} + {1'b0, b};
            OP_SUB:  sc_z = {(a < b), a - b};
            OP_SHL:  sc_z = {a, 1'b0};
            OP_SHR:  sc_z = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_ROL:  sc_z = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  sc_z = {1'b0, a[0], a[WIDTH-1:1]};
            OP_AND:  sc_z = {1'b0, a & b};
            OP_OR:   sc_z = {1'b0, a | b};
            OP_XOR:  sc_z = {1'b0, a ^ b};
            OP_NOR:  sc_z = {1'b0, ~(a | b)};
            OP_NAND: sc_z = {1'b0, ~(a & b)};
            OP_XNOR: sc_z = {1'b0, ~(a ^ b)};
            OP_EQ:   sc_z = {{WIDTH{1'b0}}, (a == b)};
            OP_GT:   sc_z = {{WIDTH{1'b0}}, (a > b)};
            default: sc_z = '0;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (op_e == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Division by zero reports all ones plus the error flag regardless of what
    // the restoring iterations leave behind.
    always_comb begin
        md_z = {(|md_hi), md_lo};
        if (op_q == OP_DIV) begin
            md_z = b_zero_q ? {(WIDTH+1){1'b1}} : {1'b0, md_lo};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            b_zero_q    <= 1'b0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op_e;
                        b_zero_q <= (b == '0);
                        if (is_iter_op(op_e)) begin
                            state_q <= ST_BUSY;
                        end else begin
                            z_q         <= sc_z;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        z_q         <= md_z;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors, backpressure,
// reset mid-operation, then randomized traffic against an arithmetic model.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] z;

    typedef struct {
        logic [8:0] z;
        int         acc;
        int         lat;
        logic [3:0] op;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic rand_ready = 1'b0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic logic [8:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int ia = int'(x);
        int ib = int'(y);
        int p;
        int r;
        case (o)
            4'd0:  r = ia + ib;
            4'd1:  r = (ia >= ib) ? ia - ib : ia - ib + 512;
            4'd2:  begin p = ia * ib; r = (p % 256) + ((p >= 256) ? 256 : 0); end
            4'd3:  r = (ib == 0) ? 511 : ia / ib;
            4'd4:  r = ia * 2;
            4'd5:  r = ia / 2 + (ia % 2) * 256;
            4'd6:  r = (ia * 2) % 256 + ia / 128;
            4'd7:  r = ia / 2 + (ia % 2) * 128;
            4'd8:  r = ia & ib;
            4'd9:  r = ia | ib;
            4'd10: r = ia ^ ib;
            4'd11: r = 255 - (ia | ib);
            4'd12: r = 255 - (ia & ib);
            4'd13: r = 255 - (ia ^ ib);
            4'd14: r = (ia == ib) ? 1 : 0;
            default: r = (ia > ib) ? 1 : 0;
        endcase
        return 9'(r);
    endfunction

    // Called at a tick; returns at the tick after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic [8:0] ez);
        exp_t e;
        int   g = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            e.z   = ez;
            e.acc = cyc;
            e.lat = (o == 4'd2 || o == 4'd3) ? 9 : 1;
            e.op  = o;
            sb.push_back(e);
            tick();
            in_valid = 1'b0;
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() > 0 && g < 2000) begin
            tick();
            g++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on each result's rise, value on transfer, stability under backpressure.
    initial begin
        logic       hold = 1'b0;
        logic       prev_ov = 1'b0;
        logic [8:0] hold_z = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold    = 1'b0;
                prev_ov = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_z", int'(z), int'(hold_z));
                end
                if (out_valid) check("in_ready_in_done", int'(in_ready), 0);
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
                    else check($sformatf("latency op%0d", sb[0].op), cyc - sb[0].acc, sb[0].lat);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("z op%0d", e.op), int'(z), int'(e.z));
                end
                hold    = out_valid && !out_ready;
                hold_z  = z;
                prev_ov = out_valid;
            end
        end
    end

    logic [3:0] dop [10] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd7, 4'd14, 4'd15};
    logic [7:0] da  [10] = '{8'hFF, 8'h03, 8'h10, 8'h0F, 8'hC8, 8'h37, 8'h81, 8'h01, 8'h5A, 8'h10};
    logic [7:0] db  [10] = '{8'h01, 8'h05, 8'h10, 8'h0F, 8'h07, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h20};
    logic [8:0] dz  [10] = '{9'h100, 9'h1FE, 9'h100, 9'h0E1, 9'h01C, 9'h1FF, 9'h140, 9'h080, 9'h001, 9'h000};

    initial begin
        logic [3:0] ro;
        logic [7:0] ra;
        logic [7:0] rb;
        int         g;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;

        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_z", int'(z), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) issue(dop[i], da[i], db[i], dz[i]);
        drain();

        // Backpressure on an ADD result for five cycles.
        out_ready = 1'b0;
        issue(4'd0, 8'h12, 8'h34, 9'h046);
        g = 0;
        while (!out_valid && g < 20) begin
            tick();
            g++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_z", int'(z), 9'h046);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);

        // Reset three cycles into a DIV discards it.
        issue(4'd3, 8'hC8, 8'h07, 9'h01C);
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        tick();
        check("after_rst_in_ready", int'(in_ready), 1);
        check("after_rst_out_valid", int'(out_valid), 0);
        issue(4'd0, 8'h20, 8'h22, 9'h042);
        drain();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) tick();
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            issue(ro, ra, rb, model(ro, ra, rb));
        end
        drain();
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
